// File: rtl/input_logic_pkg.sv
// Shared types and constants for the board input front end.
package input_logic_pkg;

  localparam int DATA_W = 10;

  // Idle level of the active-low pushbuttons.
  localparam logic KEY_RELEASED = 1'b1;

  // IDLE: no word offered. HOLD: word latched and offered until Clr.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } in_state_t;

endpackage

// File: rtl/input_logic_if.sv
// Board-side signal bundle between the input front end and its surroundings.
//
// Handshake: Valid is a held flag. It rises on the edge that latches a new DIN
// (the same edge raises the one-cycle Enter strobe) and stays high until the
// controller samples Clr high, which drops Valid on that same edge. DIN holds
// its value while Valid is high and afterwards until the next latch. Press
// events arriving while Valid is high are discarded, not queued.
interface input_logic_if;
  import input_logic_pkg::*;

  logic [DATA_W-1:0] SW;
  logic              KEYb_ENTER;
  logic              KEYb_PEEK;
  logic              Clr;
  logic [DATA_W-1:0] DIN;
  logic              Enter;
  logic              Valid;
  logic              PEEKb;
  in_state_t         dbg_state;

  modport master (
    output SW, KEYb_ENTER, KEYb_PEEK, Clr,
    input  DIN, Enter, Valid, PEEKb, dbg_state
  );

  modport slave (
    input  SW, KEYb_ENTER, KEYb_PEEK, Clr,
    output DIN, Enter, Valid, PEEKb, dbg_state
  );

endinterface

// File: rtl/debouncer.sv
// Two-flop synchronizer followed by a counting debouncer for one active-low
// pushbutton. The stable level flips only after the synchronized level has
// differed from it for DEBOUNCE_CYCLES consecutive cycles.
module debouncer
  import input_logic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Bring the asynchronous button level into the clock domain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= KEY_RELEASED;
      sync2_q <= KEY_RELEASED;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive differing cycles; flip and clear on the last one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stable_q <= KEY_RELEASED;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level_o = stable_q;

endmodule

// File: rtl/input_logic.sv
// Input front end: synchronizes the switches, debounces Enter and Peek, and
// offers each clean Enter press as a latched word held until Clr.
module input_logic
  import input_logic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic          Clock,
  input logic          Reset,
  input_logic_if.slave bus
);

  logic [DATA_W-1:0] sw_sync1_q, sw_sync2_q;
  logic              enter_lvl, peek_lvl;
  logic              enter_prev_q;
  logic              press;
  in_state_t         state_q, state_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              enter_q, enter_d;

  // Two-flop synchronizer for the switch word.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
    end else begin
      sw_sync1_q <= bus.SW;
      sw_sync2_q <= sw_sync1_q;
    end
  end

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .raw_i   (bus.KEYb_ENTER),
    .level_o (enter_lvl)
  );

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_peek_db (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .raw_i   (bus.KEYb_PEEK),
    .level_o (peek_lvl)
  );

  // Previous debounced Enter level, for falling-edge press detection.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      enter_prev_q <= KEY_RELEASED;
    end else begin
      enter_prev_q <= enter_lvl;
    end
  end

  assign press = (enter_lvl != KEY_RELEASED) && (enter_prev_q == KEY_RELEASED);

  // Next state: latch on a press in IDLE; Clr in HOLD wins over any press.
  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    enter_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (press) begin
          din_d   = sw_sync2_q;
          enter_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.Clr) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, latched word and strobe registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      din_q   <= '0;
      enter_q <= 1'b0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      enter_q <= enter_d;
    end
  end

  assign bus.DIN       = din_q;
  assign bus.Enter     = enter_q;
  assign bus.Valid     = (state_q == HOLD);
  assign bus.PEEKb     = peek_lvl;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_input_logic.sv
// Bench for input_logic with a short debounce window. A window-based model
// decides from the raw input history when each button settles and when a
// word is latched; latched words are queued and checked as Enter pulses appear.
module tb_input_logic;
  import input_logic_pkg::*;

  localparam int D  = 4;
  localparam int HN = 8192;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  input_logic_if bus();

  input_logic #(.DEBOUNCE_CYCLES(D)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Raw samples indexed by edge number since reset release. A button's
  // debounced level flips at edge n when the levels seen through the
  // synchronizer on the last D edges (raw from two edges earlier) all differ
  // from the current stable level, and all those edges follow the last flip.
  logic [DATA_W-1:0] h_sw[HN];
  logic              h_en[HN];
  logic              h_pk[HN];
  int                n;
  int                lf_en, lf_pk;
  logic              st_en, st_pk;
  logic              press_pend;
  logic              m_hold;
  logic              m_enter;
  logic [DATA_W-1:0] m_din;

  function automatic logic key_at(input bit pk, input int i);
    if (i < 1) return KEY_RELEASED;
    return pk ? h_pk[i % HN] : h_en[i % HN];
  endfunction

  function automatic logic [DATA_W-1:0] sw_at(input int i);
    if (i < 1) return '0;
    return h_sw[i % HN];
  endfunction

  function automatic logic flip_due(input bit pk, input int nn, input logic st, input int lf);
    if (nn - lf < D) return 1'b0;
    for (int j = 0; j < D; j++) begin
      if (key_at(pk, nn - 2 - j) == st) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      n = 0; lf_en = 0; lf_pk = 0;
      st_en = KEY_RELEASED; st_pk = KEY_RELEASED;
      press_pend = 1'b0; m_hold = 1'b0; m_enter = 1'b0; m_din = '0;
      exp_q.delete();
    end else begin
      n++;
      h_sw[n % HN] = bus.SW;
      h_en[n % HN] = bus.KEYb_ENTER;
      h_pk[n % HN] = bus.KEYb_PEEK;
      m_enter = 1'b0;
      if (!m_hold) begin
        if (press_pend) begin
          m_din   = sw_at(n - 2);
          m_hold  = 1'b1;
          m_enter = 1'b1;
          exp_q.push_back(m_din);
        end
      end else if (bus.Clr) begin
        m_hold = 1'b0;
      end
      press_pend = 1'b0;
      if (flip_due(1'b0, n, st_en, lf_en)) begin
        st_en = ~st_en; lf_en = n;
        press_pend = (st_en != KEY_RELEASED);
      end
      if (flip_due(1'b1, n, st_pk, lf_pk)) begin
        st_pk = ~st_pk; lf_pk = n;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("valid", 32'(bus.Valid), 32'(m_hold));
      check("state", 32'(bus.dbg_state == HOLD), 32'(m_hold));
      check("peekb", 32'(bus.PEEKb), 32'(st_pk));
      check("din_level", 32'(bus.DIN), 32'(m_din));
      check("enter_strobe", 32'(bus.Enter), 32'(m_enter));
      if (bus.Enter) begin
        if (exp_q.size() == 0) begin
          check("enter_unexpected", 32'(bus.DIN), 32'hFFFF_FFFF);
        end else begin
          check("enter_word", 32'(bus.DIN), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic press_enter(input int low_cycles, input int idle_after);
    bus.KEYb_ENTER = 1'b0;
    tick(low_cycles);
    bus.KEYb_ENTER = 1'b1;
    tick(idle_after);
  endtask

  task automatic pulse_clr();
    bus.Clr = 1'b1;
    tick(1);
    bus.Clr = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_din"},   32'(bus.DIN),   32'h0);
    check({tag, "_valid"}, 32'(bus.Valid), 32'h0);
    check({tag, "_enter"}, 32'(bus.Enter), 32'h0);
    check({tag, "_peekb"}, 32'(bus.PEEKb), 32'h1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int run_en, run_pk;
    rst            = 1'b1;
    bus.SW         = '0;
    bus.KEYb_ENTER = 1'b1;
    bus.KEYb_PEEK  = 1'b1;
    bus.Clr        = 1'b0;
    tick(3);
    check_reset_values("por");
    rst = 1'b0;
    tick(4);

    // Clean press: one pulse, word 3C1 held until Clr.
    bus.SW = 10'h3C1;
    tick(3);
    press_enter(20, 8);
    check("clean_valid_held", 32'(bus.Valid), 32'h1);
    check("clean_din", 32'(bus.DIN), 32'h3C1);
    pulse_clr();
    tick(2);

    // Bounce: 3-cycle lows separated by 1-cycle highs never settle.
    for (int k = 0; k < 5; k++) begin
      bus.KEYb_ENTER = 1'b0; tick(3);
      bus.KEYb_ENTER = 1'b1; tick(1);
    end
    tick(8);
    check("bounce_no_valid", 32'(bus.Valid), 32'h0);
    bus.SW = 10'h155;
    tick(3);
    press_enter(5, 10);
    check("bounce_late_press", 32'(bus.DIN), 32'h155);
    pulse_clr();
    tick(2);

    // HOLD discard: a second press while holding is dropped.
    bus.SW = 10'h0F0;
    tick(3);
    press_enter(10, 10);
    bus.SW = 10'h011;
    tick(3);
    press_enter(10, 10);
    check("discard_din", 32'(bus.DIN), 32'h0F0);
    pulse_clr();
    tick(1);
    check("discard_cleared", 32'(bus.Valid), 32'h0);
    press_enter(10, 10);
    check("discard_next_word", 32'(bus.DIN), 32'h011);

    // Press event coinciding with Clr in HOLD: Clr wins.
    bus.SW = 10'h2FF;
    bus.KEYb_ENTER = 1'b0;
    tick(6);
    bus.Clr = 1'b1;
    tick(1);
    bus.Clr = 1'b0;
    tick(6);
    bus.KEYb_ENTER = 1'b1;
    tick(8);
    check("simul_idle", 32'(bus.Valid), 32'h0);
    check("simul_din", 32'(bus.DIN), 32'h011);

    // Peek: 10-cycle press then a 2-cycle glitch.
    bus.KEYb_PEEK = 1'b0; tick(6);
    check("peek_pressed", 32'(bus.PEEKb), 32'h0);
    tick(4);
    bus.KEYb_PEEK = 1'b1; tick(6);
    check("peek_released", 32'(bus.PEEKb), 32'h1);
    tick(4);
    bus.KEYb_PEEK = 1'b0; tick(2);
    bus.KEYb_PEEK = 1'b1; tick(8);
    check("peek_glitch", 32'(bus.PEEKb), 32'h1);

    // Randomized phase: mixed-length runs on both buttons, random SW and Clr.
    run_en = 0;
    run_pk = 0;
    for (int c = 0; c < 2000; c++) begin
      if (run_en == 0) begin
        bus.KEYb_ENTER = ~bus.KEYb_ENTER;
        run_en = $urandom_range(1, 10);
      end else begin
        run_en--;
      end
      if (run_pk == 0) begin
        bus.KEYb_PEEK = ~bus.KEYb_PEEK;
        run_pk = $urandom_range(1, 10);
      end else begin
        run_pk--;
      end
      bus.SW  = 10'($urandom);
      bus.Clr = ($urandom_range(0, 7) == 0);
      tick(1);
    end
    bus.KEYb_ENTER = 1'b1;
    bus.KEYb_PEEK  = 1'b1;
    bus.Clr        = 1'b0;
    tick(10);
    pulse_clr();
    tick(2);

    // Reset mid-HOLD with 2A5 latched and Peek held down.
    bus.SW        = 10'h2A5;
    bus.KEYb_PEEK = 1'b0;
    tick(3);
    bus.KEYb_ENTER = 1'b0;
    tick(12);
    check("pre_reset_din", 32'(bus.DIN), 32'h2A5);
    check("pre_reset_peek", 32'(bus.PEEKb), 32'h0);
    rst = 1'b1;
    #1;
    check_reset_values("mid_hold_reset");
    tick(2);
    bus.KEYb_ENTER = 1'b1;
    bus.KEYb_PEEK  = 1'b1;
    rst = 1'b0;
    tick(4);
    check_reset_values("post_reset");

    // Debounce restarts from released level after reset.
    bus.SW = 10'h1E3;
    tick(3);
    press_enter(8, 10);
    check("after_reset_word", 32'(bus.DIN), 32'h1E3);
    pulse_clr();
    tick(4);

    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
